// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch side.
// Contents: width constants, the opcode values the fetch unit and
// ControlUnit agree on, and the 2-bit fetch sequencer state encoding.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 6;

  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPC_W-1:0] OP_JAL  = 6'b000011;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc         in  32  address of the current instruction
//   imm_field  in  26  Instr[25:0] (jump index; low 16 bits are the branch offset)
//   jump       in  1   ControlUnit Jump
//   branch     in  1   ControlUnit Branch
//   zero       in  1   ALU Zero flag
//   pc_plus4   out 32  pc + 4, modulo 2^32
//   next_pc    out 32  selected successor address (Jump > Branch&Zero > pc+4)
module pc_next_calc
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] pc,
  input  logic [25:0]        imm_field,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  output logic [INSTR_W-1:0] pc_plus4,
  output logic [INSTR_W-1:0] next_pc
);

  logic [INSTR_W-1:0] branch_off;
  logic [INSTR_W-1:0] branch_target;
  logic [INSTR_W-1:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  // Sign-extended word offset, already shifted left by 2.
  assign branch_off    = {{14{imm_field[15]}}, imm_field[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  // Jumps stay inside the 256 MB region of the delay-slot address.
  assign jump_target   = {pc_plus4[31:28], imm_field, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side sequencer: holds the PC, fetches words from instruction
// memory and presents the instruction register to the ControlUnit.
// Parameters:
//   RESET_PC     PC loaded on reset (word aligned)
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   IMemReq      out  fetch request (asserted throughout FETCH)
//   IMemAddr     out  fetch address, equal to PC
//   IMemValid    in   memory returns IMemData this cycle (only used in FETCH)
//   IMemData     in   instruction word
//   Stall        in   downstream not ready, hold the current instruction
//   Jump/Branch  in   from ControlUnit, sampled in ISSUE when Stall=0
//   Zero         in   ALU zero flag, sampled with Jump/Branch
//   Instr        out  instruction register
//   InstrOpCode  out  Instr[31:26]
//   InstrValid   out  Instr is live for decode (ISSUE)
//   PC           out  address of Instr
//   PCPlus4      out  PC + 4
//   Halted       out  halt opcode retired
//   fetch_state  out  current sequencer state (debug)
//
// Handshake: the request is a level, not a pulse. IMemReq stays high and
// IMemAddr stays stable from the first FETCH cycle until the cycle in
// which IMemValid is sampled high; that edge captures IMemData and ends
// the request. IMemValid in any other state is ignored.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               IMemReq,
  output logic [INSTR_W-1:0] IMemAddr,
  input  logic               IMemValid,
  input  logic [INSTR_W-1:0] IMemData,
  input  logic               Stall,
  input  logic               Jump,
  input  logic               Branch,
  input  logic               Zero,
  output logic [INSTR_W-1:0] Instr,
  output logic [OPC_W-1:0]   InstrOpCode,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] PC,
  output logic [INSTR_W-1:0] PCPlus4,
  output logic               Halted,
  output fetch_state_t       fetch_state
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] next_pc;
  logic               capture;
  logic               pc_load;

  pc_next_calc u_pc_next_calc (
    .pc        (pc_q),
    .imm_field (instr_q[25:0]),
    .jump      (Jump),
    .branch    (Branch),
    .zero      (Zero),
    .pc_plus4  (PCPlus4),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc_q    <= RESET_PC & ~32'd3;
      instr_q <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        instr_q <= IMemData;
      end
      if (pc_load) begin
        pc_q <= next_pc & ~32'd3;
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    pc_load    = 1'b0;
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    Halted     = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        IMemReq = 1'b1;
        if (IMemValid) begin
          capture    = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        InstrValid = 1'b1;
        if (!Stall) begin
          if (instr_q[31:26] == OP_HALT) begin
            state_next = ST_HALT;
          end else begin
            pc_load    = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign IMemAddr    = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign InstrOpCode = instr_q[31:26];
  assign fetch_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit. The bench plays the
// instruction memory and the ControlUnit, and predicts every fetch address
// from the MIPS next-PC rules using plain integer arithmetic.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clk;
  logic               rst_n;
  logic               IMemReq;
  logic [31:0]        IMemAddr;
  logic               IMemValid;
  logic [31:0]        IMemData;
  logic               Stall;
  logic               Jump;
  logic               Branch;
  logic               Zero;
  logic [31:0]        Instr;
  logic [5:0]         InstrOpCode;
  logic               InstrValid;
  logic [31:0]        PC;
  logic [31:0]        PCPlus4;
  logic               Halted;
  fetch_state_t       fetch_state;

  int                 checks = 0;
  int                 errors = 0;
  logic [31:0]        exp_q[$];   // expected fetch addresses, in order
  logic [31:0]        exp_pc;
  logic [31:0]        exp_instr;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemValid   (IMemValid),
    .IMemData    (IMemData),
    .Stall       (Stall),
    .Jump        (Jump),
    .Branch      (Branch),
    .Zero        (Zero),
    .Instr       (Instr),
    .InstrOpCode (InstrOpCode),
    .InstrValid  (InstrValid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .Halted      (Halted),
    .fetch_state (fetch_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference next-PC, straight from the ISA rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    if (b && z) begin
      off = int'($signed(ins[15:0]));
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] d;
    d = $urandom;
    if (d[31:26] == 6'h3F) d[31] = 1'b0;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  // Reset for one edge with a stray memory response that must be dropped.
  task automatic do_reset();
    rst_n     = 1'b0;
    IMemValid = 1'b1;
    IMemData  = $urandom;
    @(negedge clk);
    rst_n     = 1'b1;
    IMemValid = 1'b0;
    check("rst_pc", PC, RESET_PC);
    check("rst_instr", Instr, 32'h0);
    check("rst_req", IMemReq, 1'b0);
    check("rst_valid", InstrValid, 1'b0);
    check("rst_halted", Halted, 1'b0);
    check("rst_pcplus4", PCPlus4, RESET_PC + 32'd4);
    check("rst_state", fetch_state, ST_IDLE);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    @(negedge clk);
    check("first_req", IMemReq, 1'b1);
  endtask

  // Serve one fetch with the given number of wait cycles.
  task automatic fetch(input logic [31:0] data, input int waits);
    int n;
    n = 0;
    while (IMemReq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", IMemReq, 1'b1);
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("fetch_addr", IMemAddr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      IMemValid = 1'b0;
      @(negedge clk);
      check("wait_req", IMemReq, 1'b1);
      check("wait_addr", IMemAddr, exp_pc);
      check("wait_nvalid", InstrValid, 1'b0);
    end
    IMemValid = 1'b1;
    IMemData  = data;
    @(negedge clk);
    IMemValid = 1'b0;
    IMemData  = $urandom;
    exp_instr = data;
    check("cap_valid", InstrValid, 1'b1);
    check("cap_instr", Instr, data);
    check("cap_opcode", InstrOpCode, data[31:26]);
    check("cap_pc", PC, exp_pc);
    check("cap_pcplus4", PCPlus4, exp_pc + 32'd4);
    check("cap_req", IMemReq, 1'b0);
  endtask

  // Hold ISSUE for 'stalls' cycles (with misleading controls and stray
  // memory responses), then release with the given controls.
  task automatic issue(input logic j, input logic b, input logic z, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      Stall     = 1'b1;
      Jump      = 1'($urandom);
      Branch    = 1'($urandom);
      Zero      = 1'($urandom);
      IMemValid = 1'b1;
      IMemData  = $urandom;
      @(negedge clk);
      check("stall_valid", InstrValid, 1'b1);
      check("stall_instr", Instr, exp_instr);
      check("stall_pc", PC, exp_pc);
      check("stall_req", IMemReq, 1'b0);
    end
    IMemValid = 1'b0;
    Stall     = 1'b0;
    Jump      = j;
    Branch    = b;
    Zero      = z;
    @(negedge clk);
    Jump   = 1'b0;
    Branch = 1'b0;
    Zero   = 1'b0;
    if (exp_instr[31:26] == 6'h3F) begin
      check("halt_halted", Halted, 1'b1);
      check("halt_req", IMemReq, 1'b0);
      check("halt_valid", InstrValid, 1'b0);
    end else begin
      exp_q.push_back(model_next(exp_pc, exp_instr, j, b, z));
      check("issue_req", IMemReq, 1'b1);
      check("issue_valid", InstrValid, 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    IMemValid = 1'b0;
    IMemData  = '0;
    Stall     = 1'b0;
    Jump      = 1'b0;
    Branch    = 1'b0;
    Zero      = 1'b0;
    exp_pc    = '0;
    exp_instr = '0;

    // Reset and linear fetch: addresses 0, 4, 8.
    do_reset();
    fetch(32'h2008_0005, 0);
    issue(1'b0, 1'b0, 1'b0, 0);
    fetch(32'h2009_0003, 0);
    issue(1'b0, 1'b1, 1'b0, 0);

    // Wait states and stall at address 8.
    fetch(rand_instr(), 3);
    issue(1'b0, 1'b0, 1'b0, 2);

    // Jump to 0x10, then branch taken (-> 0x0C), jump back, branch not taken.
    fetch(32'h0800_0004, 0);
    issue(1'b1, 1'b0, 1'b0, 0);
    fetch(32'h1000_FFFE, 0);
    issue(1'b0, 1'b1, 1'b1, 0);
    check("br_taken_addr", IMemAddr, 32'h0000_000C);
    fetch(32'h0800_0004, 1);
    issue(1'b1, 1'b0, 1'b0, 0);
    fetch(32'h1000_FFFE, 0);
    issue(1'b0, 1'b1, 1'b0, 0);
    check("br_not_taken_addr", IMemAddr, 32'h0000_0014);

    // Jump into 0x0040_0000, then Jump and Branch together.
    fetch(32'h0810_0000, 0);
    issue(1'b1, 1'b0, 1'b0, 0);
    fetch(32'h0810_0004, 0);
    issue(1'b1, 1'b1, 1'b1, 1);
    check("jump_prio_addr", IMemAddr, 32'h0040_0010);

    // Randomized traffic.
    for (int k = 0; k < 12; k++) begin
      fetch(rand_instr(), $urandom_range(0, 2));
      issue(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    // Reset in the middle of a FETCH wait.
    IMemValid = 1'b0;
    @(negedge clk);
    check("pre_rst_req", IMemReq, 1'b1);
    do_reset();

    // Wrap-around: branch back from 0 to 0xFFFF_FFFC, then fall through to 0.
    fetch(32'h1000_FFFE, 0);
    issue(1'b0, 1'b1, 1'b1, 0);
    check("wrap_addr_hi", IMemAddr, 32'hFFFF_FFFC);
    fetch(32'h2008_0001, 0);
    check("wrap_pcplus4", PCPlus4, 32'h0000_0000);
    issue(1'b0, 1'b0, 1'b0, 0);
    check("wrap_addr_lo", IMemAddr, 32'h0000_0000);

    // Halt: must persist regardless of memory or control activity.
    fetch(32'hFC00_0000, 1);
    issue(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      IMemValid = 1'b1;
      IMemData  = $urandom;
      Jump      = 1'($urandom);
      @(negedge clk);
      check("halt_hold", Halted, 1'b1);
      check("halt_hold_req", IMemReq, 1'b0);
      check("halt_hold_valid", InstrValid, 1'b0);
      check("halt_hold_instr", Instr, 32'hFC00_0000);
    end
    IMemValid = 1'b0;
    Jump      = 1'b0;

    // Reset out of HALT and run one more instruction.
    do_reset();
    fetch(32'h2008_0005, 0);
    issue(1'b0, 1'b0, 1'b0, 0);
    check("post_halt_addr", IMemAddr, RESET_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side sequencer for the MIPS core: the producer end of the opcode/control interface. It holds the PC, fetches words from instruction memory over a request/valid handshake, and presents the instruction register with `InstrOpCode` to the ControlUnit. It consumes ControlUnit's `Jump`/`Branch` and the ALU `Zero` flag to select the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `IMemReq`  out  1  fetch request to instruction memory.
- `IMemAddr`  out  32  fetch address (= PC), word aligned.
- `IMemValid`  in  1  memory returns `IMemData` this cycle.
- `IMemData`  in  32  instruction word.
- `Stall`  in  1  downstream not ready; hold the current instruction.
- `Jump`  in  1  from ControlUnit.
- `Branch`  in  1  from ControlUnit.
- `Zero`  in  1  from ALU.
- `Instr`  out  32  instruction register.
- `InstrOpCode`  out  6  `Instr[31:26]`, to ControlUnit.
- `InstrValid`  out  1  `Instr` is live for decode.
- `PC`  out  32  address of `Instr`.
- `PCPlus4`  out  32  `PC + 4`, mod 2^32.
- `Halted`  out  1  halt opcode retired.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: entered on reset; unconditionally goes to FETCH on the next cycle.
- FETCH:
  - `IMemReq`=1; `IMemAddr`=PC, held stable until `IMemValid`.
  - On `IMemValid`: capture `IMemData` into `Instr` and go to ISSUE.
- ISSUE:
  - `InstrValid`=1; `Instr` and `PC` are held.
  - If `Stall`=1, stay in ISSUE.
  - Else, if `InstrOpCode`==OP_HALT (6'b111111), go to HALT.
  - Else, load the next PC and go to FETCH.
- HALT: `Halted`=1, `InstrValid`=0, `IMemReq`=0. Exit only via reset.
- Next PC (priority order):
  - `Jump`: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - `Branch`&`Zero`: PCPlus4 + (signext(Instr[15:0]) << 2).
  - Otherwise: PCPlus4.
- All arithmetic is 32-bit, modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0.
- `Branch` without `Zero` falls through. `Jump` and `Branch` both set: `Jump` wins.
- `IMemValid` is ignored outside FETCH.
- PC bits [1:0] are forced to 0 on every load.

## Timing
- Reset (`rst_n`=0 at a rising edge) gives:
  - PC=`RESET_PC`, `Instr`=0, state=IDLE.
  - `IMemReq`=0, `InstrValid`=0, `Halted`=0.
  - `PCPlus4`=`RESET_PC`+4.
- Reset dominates every state, including mid-FETCH and HALT. A pending memory response is dropped.
- First `IMemReq` is asserted 1 cycle after `rst_n` rises.
- With zero-wait memory (`IMemValid` in the same cycle as `IMemReq`): `InstrValid` rises 1 cycle after capture. Throughput is 2 cycles per instruction.
- Each memory wait cycle adds 1 cycle.
- `Jump`/`Branch`/`Zero` are sampled only in ISSUE cycles with `Stall`=0. The new PC appears on `IMemAddr` the following cycle.
- `InstrOpCode` changes only on the capture edge, so ControlUnit outputs are stable throughout ISSUE.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants OP_J, OP_JAL, OP_BEQ, OP_HALT.
  - Fetch state encoding (2-bit).
  - Width constants INSTR_W=32, OPC_W=6.
- Sub-module `pc_next_calc`: combinational next-PC mux, adders and sign extension. The top level holds the FSM, PC register and instruction register.

## Test plan
- Reset and linear fetch:
  - Stimulus: `RESET_PC`=0, memory returns 32'h2008_0005, 32'h2009_0003 with zero wait.
  - Response: `IMemAddr` sequence 0, 4, 8. `InstrOpCode`=6'b001000 with `InstrValid` on cycles 2 and 4.
- Wait states and stall:
  - Stimulus: `IMemValid` delayed 3 cycles; then `Stall`=1 for 2 ISSUE cycles.
  - Response: `IMemAddr` stable during the wait; `Instr` and `PC` unchanged while stalled; next fetch at PC+4.
- Branch taken/not taken:
  - Stimulus: PC=32'h10, `Instr`=32'h1000_FFFE, `Branch`=1.
  - Response: `Zero`=1 → next `IMemAddr`=32'h0C; `Zero`=0 → 32'h14.
- Jump:
  - Stimulus: PC=32'h0040_0000, `Instr`=32'h0810_0004, `Jump`=1, `Branch`=1.
  - Response: next `IMemAddr`=32'h0040_0010 (jump has priority).
- Halt and reset mid-operation:
  - Stimulus: fetch 32'hFC00_0000.
  - Response: `Halted`=1 and `IMemReq`=0 persist.
  - Stimulus: `rst_n`=0 for 1 cycle during a FETCH wait.
  - Response: PC=`RESET_PC`, fetch restarts from it.
- Wrap-around:
  - Stimulus: PC=32'hFFFF_FFFC, non-branch instruction.
  - Response: `PCPlus4`=0, next `IMemAddr`=0.
